// File: rtl/quick_branch_btb_if.sv
// quick_branch_btb_if: fetch lookup and execute update bus of the branch target buffer
interface quick_branch_btb_if #(parameter int PC_WIDTH = 10);
   logic [PC_WIDTH-1:0] current_pc;
   logic                read_hit;
   logic                predict_taken;
   logic [PC_WIDTH-1:0] jump_pc;
   logic                we;
   logic [PC_WIDTH-1:0] update_pc;
   logic [PC_WIDTH-1:0] store_pc;
   logic                taken;
   logic                flush;
   modport master (output current_pc, we, update_pc, store_pc, taken, flush,
                   input read_hit, predict_taken, jump_pc);
   modport slave (input current_pc, we, update_pc, store_pc, taken, flush,
                  output read_hit, predict_taken, jump_pc);
endinterface

// File: rtl/quick_branch_btb.sv
// quick_branch_btb: 2-way set-associative BTB with 2-bit counters and update-driven LRU
module quick_branch_btb #(
   parameter int PC_WIDTH   = 10,
   parameter int INDEX_BITS = 3,
   parameter int CTR_INIT   = 2
) (
   input logic               clk,
   input logic               rst,
   quick_branch_btb_if.slave bus
);
   localparam int SETS = 2 ** INDEX_BITS;
   localparam int TAG  = PC_WIDTH - INDEX_BITS;
   logic [TAG-1:0]      tag_q   [2][SETS];
   logic [PC_WIDTH-1:0] tgt_q   [2][SETS];
   logic [1:0]          ctr_q   [2][SETS];
   logic                valid_q [2][SETS];
   logic                lru_q   [SETS];
   logic [INDEX_BITS-1:0] ridx, uidx;
   logic [TAG-1:0]        rtag, utag;
   logic rh0, rh1, rw, uh0, uh1, uhit, uw, victim;
   logic [1:0] uctr;
   always_comb begin
      ridx = bus.current_pc[INDEX_BITS-1:0];
      rtag = bus.current_pc[PC_WIDTH-1:INDEX_BITS];
      rh0 = valid_q[0][ridx] && tag_q[0][ridx] == rtag;
      rh1 = valid_q[1][ridx] && tag_q[1][ridx] == rtag;
      rw = !rh0;
      bus.read_hit = rh0 | rh1;
      bus.predict_taken = bus.read_hit & ctr_q[rw][ridx][1];
      bus.jump_pc = bus.read_hit ? tgt_q[rw][ridx] : '0;
   end
   always_comb begin
      uidx = bus.update_pc[INDEX_BITS-1:0];
      utag = bus.update_pc[PC_WIDTH-1:INDEX_BITS];
      uh0 = valid_q[0][uidx] && tag_q[0][uidx] == utag;
      uh1 = valid_q[1][uidx] && tag_q[1][uidx] == utag;
      uhit = uh0 | uh1;
      uw = !uh0;
      victim = !valid_q[0][uidx] ? 1'b0 : !valid_q[1][uidx] ? 1'b1 : lru_q[uidx];
      uctr = bus.taken ? (ctr_q[uw][uidx] == 2'd3 ? 2'd3 : ctr_q[uw][uidx] + 2'd1)
                       : (ctr_q[uw][uidx] == 2'd0 ? 2'd0 : ctr_q[uw][uidx] - 2'd1);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++) begin
               valid_q[w][s] <= 1'b0;
               ctr_q[w][s] <= '0;
               tgt_q[w][s] <= '0;
               tag_q[w][s] <= '0;
            end
         for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
      end else if (bus.flush) begin
         for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
         for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
      end else if (bus.we) begin
         if (uhit) begin
            ctr_q[uw][uidx] <= uctr;
            if (bus.taken) tgt_q[uw][uidx] <= bus.store_pc;
            lru_q[uidx] <= ~uw;
         end else if (bus.taken) begin
            tag_q[victim][uidx] <= utag;
            tgt_q[victim][uidx] <= bus.store_pc;
            ctr_q[victim][uidx] <= 2'(CTR_INIT);
            valid_q[victim][uidx] <= 1'b1;
            lru_q[uidx] <= ~victim;
         end
      end
   end
endmodule

// File: tb/tb_quick_branch_btb.sv
// tb_quick_branch_btb: table-driven cycle vectors with an expected-result queue
module tb_quick_branch_btb;
   typedef struct packed {
      logic       rst;
      logic       fl;
      logic       we;
      logic [9:0] upc;
      logic [9:0] spc;
      logic       tk;
      logic [9:0] cpc;
      logic       chk;
      logic       eh;
      logic       ept;
      logic [9:0] ej;
   } vec_t;
   typedef struct packed {
      logic       chk;
      logic       eh;
      logic       ept;
      logic [9:0] ej;
      int         id;
   } exp_t;
   logic clk = 1'b0;
   logic rst;
   int compared = 0;
   int mismatched = 0;
   exp_t sb[$];
   vec_t tbl[31];
   quick_branch_btb_if #(.PC_WIDTH(10)) bus ();
   quick_branch_btb #(.PC_WIDTH(10), .INDEX_BITS(3), .CTR_INIT(2)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic vec_t v(input logic r, input logic f, input logic w, input int u, input int s,
                              input logic t, input int c, input logic k, input logic h,
                              input logic p, input int j);
      v = '{r, f, w, 10'(u), 10'(s), t, 10'(c), k, h, p, 10'(j)};
   endfunction
   task automatic check(input string nm, input int id, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s row %0d: got %0d, expected %0d", nm, id, act, req);
      end
   endtask
   task automatic apply(input vec_t x, input int id);
      exp_t e;
      @(posedge clk);
      #1;
      rst = x.rst;
      bus.flush = x.fl;
      bus.we = x.we;
      bus.update_pc = x.upc;
      bus.store_pc = x.spc;
      bus.taken = x.tk;
      bus.current_pc = x.cpc;
      sb.push_back('{x.chk, x.eh, x.ept, x.ej, id});
      #4;
      e = sb.pop_front();
      if (e.chk) begin
         check("read_hit", e.id, int'(bus.read_hit), int'(e.eh));
         check("predict_taken", e.id, int'(bus.predict_taken), int'(e.ept));
         check("jump_pc", e.id, int'(bus.jump_pc), int'(e.ej));
      end
   endtask
   initial begin
      // rst fl we upc spc tk cpc chk hit pt jpc
      tbl[0]  = v(0, 0, 0,  0,   0, 0, 10, 0, 0, 0,   0);
      tbl[1]  = v(0, 0, 1, 10,  20, 1, 10, 1, 0, 0,   0);
      tbl[2]  = v(1, 0, 1, 10,  20, 1, 10, 1, 0, 0,   0);
      tbl[3]  = v(1, 0, 1, 10, 999, 0, 10, 1, 1, 1,  20);
      tbl[4]  = v(1, 0, 1, 10,   0, 0, 11, 1, 0, 0,   0);
      tbl[5]  = v(1, 0, 1, 10,   0, 0, 10, 1, 1, 0,  20);
      tbl[6]  = v(1, 0, 1, 10,  30, 1, 10, 1, 1, 0,  20);
      tbl[7]  = v(1, 0, 1, 10,  30, 1, 10, 1, 1, 0,  30);
      tbl[8]  = v(1, 0, 1, 10,  30, 1, 10, 1, 1, 1,  30);
      tbl[9]  = v(1, 0, 1, 10,  30, 1, 10, 1, 1, 1,  30);
      tbl[10] = v(1, 0, 1, 10,   0, 0, 10, 1, 1, 1,  30);
      tbl[11] = v(1, 0, 1, 10,   0, 0, 10, 1, 1, 1,  30);
      tbl[12] = v(1, 0, 0,  0,   0, 0, 10, 1, 1, 0,  30);
      tbl[13] = v(1, 1, 1, 50,  77, 1, 10, 1, 1, 0,  30);
      tbl[14] = v(1, 0, 1,  2, 100, 1, 10, 1, 0, 0,   0);
      tbl[15] = v(1, 0, 1, 10, 110, 1, 50, 1, 0, 0,   0);
      tbl[16] = v(1, 0, 1,  2, 100, 1,  2, 1, 1, 1, 100);
      tbl[17] = v(1, 0, 1, 18, 118, 1, 10, 1, 1, 1, 110);
      tbl[18] = v(1, 0, 0,  0,   0, 0, 10, 1, 0, 0,   0);
      tbl[19] = v(1, 0, 0,  0,   0, 0,  2, 1, 1, 1, 100);
      tbl[20] = v(1, 0, 0,  0,   0, 0, 18, 1, 1, 1, 118);
      tbl[21] = v(1, 0, 1, 26,   5, 0, 18, 1, 1, 1, 118);
      tbl[22] = v(1, 0, 1, 34, 134, 1, 26, 1, 0, 0,   0);
      tbl[23] = v(1, 0, 0,  0,   0, 0,  2, 1, 0, 0,   0);
      tbl[24] = v(1, 0, 0,  0,   0, 0, 34, 1, 1, 1, 134);
      tbl[25] = v(1, 0, 0,  0,   0, 0, 18, 1, 1, 1, 118);
      tbl[26] = v(0, 0, 1,  5,  55, 1, 34, 1, 1, 1, 134);
      tbl[27] = v(1, 0, 0,  0,   0, 0, 34, 1, 0, 0,   0);
      tbl[28] = v(1, 0, 1,  5,  55, 1,  5, 1, 0, 0,   0);
      tbl[29] = v(1, 0, 0,  0,   0, 0,  5, 1, 1, 1,  55);
      tbl[30] = v(1, 0, 0,  0,   0, 0, 18, 1, 0, 0,   0);
      for (int i = 0; i < 31; i++) apply(tbl[i], i);
      // same-cycle update must stay invisible until the following lookup
      apply(v(1, 0, 1, 7, 70, 1, 7, 1, 0, 0, 0), 100);
      apply(v(1, 0, 1, 15, 75, 1, 7, 1, 1, 1, 70), 101);
      apply(v(1, 0, 0, 0, 0, 0, 15, 1, 1, 1, 75), 102);
      apply(v(1, 0, 0, 0, 0, 0, 7, 1, 1, 1, 70), 103);
      // flush without a concurrent update clears set 7 entirely
      apply(v(1, 1, 0, 0, 0, 0, 15, 1, 1, 1, 75), 104);
      apply(v(1, 0, 0, 0, 0, 0, 15, 1, 0, 0, 0), 105);
      apply(v(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0), 106);
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
